// File: rtl/robot_nav_ctrl.sv
// -----------------------------------------------------------------------------
// robot_nav_ctrl
// Obstacle-avoidance controller placed between the distance-sensor front end
// and the motor driver. Channel 0 is the front sensor; channels 1..N_CH-1 are
// side sensors used to choose a turn direction. A Moore FSM produces speed and
// turn commands. The FSM applies threshold hysteresis, timed stop and turn
// phases, and bounded turn retries. A watchdog detects a stale sensor feed.
//
// Ports
//   clk        : clock
//   rstn       : synchronous reset, active-low
//   dist_v     : packed samples, channel k at [k*DIST_W +: DIST_W]
//   dist_valid : dist_v carries a new sample set this cycle
//   speed      : 0 stop, 1 slow, 2 fast
//   turn_en    : high while turning
//   turn_sel   : side channel chosen for the current/last turn
//   state_o    : IDLE=0 FWD=1 SLOW=2 STOP=3 TURN=4 FAULT=5
//   alarm      : high in FAULT
//   fault_code : 01 watchdog, 10 stuck, 00 otherwise
// -----------------------------------------------------------------------------
module robot_nav_ctrl #(
   parameter int DIST_W    = 16,
   parameter int N_CH      = 3,
   parameter int STOP_TH   = 100,
   parameter int SLOW_TH   = 300,
   parameter int HYST      = 20,
   parameter int STOP_CYC  = 4,
   parameter int TURN_CYC  = 8,
   parameter int MAX_RETRY = 3,
   parameter int WDOG_CYC  = 64,
   localparam int SEL_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic [N_CH*DIST_W-1:0]   dist_v,
   input  logic                     dist_valid,
   output logic [1:0]               speed,
   output logic                     turn_en,
   output logic [SEL_W-1:0]         turn_sel,
   output logic [2:0]               state_o,
   output logic                     alarm,
   output logic [1:0]               fault_code
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FWD   = 3'd1,
      ST_SLOW  = 3'd2,
      ST_STOP  = 3'd3,
      ST_TURN  = 3'd4,
      ST_FAULT = 3'd5
   } state_t;

   localparam int CNT_MAX = (STOP_CYC > TURN_CYC) ? STOP_CYC : TURN_CYC;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int WD_W    = $clog2(WDOG_CYC + 1);
   localparam int RT_W    = $clog2(MAX_RETRY + 1);

   localparam logic [DIST_W-1:0] STOP_LO = DIST_W'(STOP_TH);
   localparam logic [DIST_W-1:0] SLOW_LO = DIST_W'(SLOW_TH);
   // Upward thresholds carry one extra bit so a sum beyond the sample range
   // can never be reached by any sample.
   localparam logic [DIST_W:0]   STOP_HI = (DIST_W+1)'(STOP_TH) + (DIST_W+1)'(HYST);
   localparam logic [DIST_W:0]   SLOW_HI = (DIST_W+1)'(SLOW_TH) + (DIST_W+1)'(HYST);

   localparam logic [1:0] FC_NONE = 2'b00;
   localparam logic [1:0] FC_WDOG = 2'b01;
   localparam logic [1:0] FC_STUCK = 2'b10;

   // Speed command implied by a state.
   function automatic logic [1:0] speed_of(input state_t s);
      logic [1:0] r;
      case (s)
         ST_FWD:  r = 2'd2;
         ST_SLOW: r = 2'd1;
         default: r = 2'd0;
      endcase
      return r;
   endfunction

   logic [DIST_W-1:0] sample_q [N_CH];
   logic [DIST_W-1:0] sample_d [N_CH];
   logic              eval_q, eval_d;
   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [RT_W-1:0]   retry_q, retry_d;
   logic [WD_W-1:0]   wdog_q, wdog_d;
   logic [SEL_W-1:0]  sel_q, sel_d;
   logic [1:0]        fc_q, fc_d;
   logic [1:0]        speed_q, speed_d;
   logic              turn_en_q, turn_en_d;
   logic              alarm_q, alarm_d;

   logic [DIST_W-1:0] front;
   logic [DIST_W-1:0] best_val;
   logic [SEL_W-1:0]  best_idx;
   logic              wdog_hit;

   // Capture a full sample set on dist_valid; remember that an evaluation is due.
   always_comb begin
      for (int k = 0; k < N_CH; k++) begin
         if (dist_valid) begin
            sample_d[k] = dist_v[k*DIST_W +: DIST_W];
         end else begin
            sample_d[k] = sample_q[k];
         end
      end
      eval_d = dist_valid;
   end

   // Widest side channel; strict compare keeps the lowest index on ties.
   always_comb begin
      best_val = '0;
      best_idx = '0;
      front    = sample_q[0];
      for (int k = 1; k < N_CH; k++) begin
         if ((k == 1) || (sample_q[k] > best_val)) begin
            best_val = sample_q[k];
            best_idx = SEL_W'(k);
         end else begin
            best_val = best_val;
         end
      end
   end

   // Watchdog counter: cleared by a capture, saturating otherwise, frozen in FAULT.
   always_comb begin
      wdog_hit = (state_q != ST_FAULT) && !dist_valid &&
                 (wdog_q == WD_W'(WDOG_CYC - 1));
      if (state_q == ST_FAULT) begin
         if ((fc_q == FC_WDOG) && dist_valid) begin
            wdog_d = '0;
         end else begin
            wdog_d = wdog_q;
         end
      end else if (dist_valid) begin
         wdog_d = '0;
      end else if (wdog_q < WD_W'(WDOG_CYC)) begin
         wdog_d = wdog_q + WD_W'(1);
      end else begin
         wdog_d = wdog_q;
      end
   end

   // Next-state, phase counters, retry count, turn selection and fault code.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      retry_d = retry_q;
      sel_d   = sel_q;
      fc_d    = fc_q;
      if (wdog_hit) begin
         state_d = ST_FAULT;
         fc_d    = FC_WDOG;
         cnt_d   = '0;
         retry_d = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               cnt_d = '0;
               if (eval_q) begin
                  if (front < STOP_LO) begin
                     state_d = ST_STOP;
                  end else if (front < SLOW_LO) begin
                     state_d = ST_SLOW;
                  end else begin
                     state_d = ST_FWD;
                  end
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_FWD: begin
               cnt_d = '0;
               if (eval_q && (front < STOP_LO)) begin
                  state_d = ST_STOP;
               end else if (eval_q && (front < SLOW_LO)) begin
                  state_d = ST_SLOW;
               end else begin
                  state_d = ST_FWD;
               end
            end
            ST_SLOW: begin
               cnt_d = '0;
               if (eval_q && (front < STOP_LO)) begin
                  state_d = ST_STOP;
               end else if (eval_q && ({1'b0, front} >= SLOW_HI)) begin
                  state_d = ST_FWD;
               end else begin
                  state_d = ST_SLOW;
               end
            end
            ST_STOP: begin
               if (cnt_q == CNT_W'(STOP_CYC - 1)) begin
                  state_d = ST_TURN;
                  cnt_d   = '0;
                  sel_d   = best_idx;
                  retry_d = RT_W'(1);
               end else begin
                  cnt_d   = cnt_q + CNT_W'(1);
               end
            end
            ST_TURN: begin
               if (cnt_q == CNT_W'(TURN_CYC - 1)) begin
                  cnt_d = '0;
                  if ({1'b0, front} >= STOP_HI) begin
                     state_d = ST_SLOW;
                     retry_d = '0;
                  end else if (retry_q == RT_W'(MAX_RETRY)) begin
                     state_d = ST_FAULT;
                     fc_d    = FC_STUCK;
                  end else begin
                     state_d = ST_TURN;
                     sel_d   = best_idx;
                     retry_d = retry_q + RT_W'(1);
                  end
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            ST_FAULT: begin
               // A stuck fault is sticky; only a watchdog fault recovers.
               if ((fc_q == FC_WDOG) && dist_valid) begin
                  state_d = ST_IDLE;
                  fc_d    = FC_NONE;
               end else begin
                  state_d = ST_FAULT;
               end
            end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               retry_d = '0;
               fc_d    = FC_NONE;
            end
         endcase
      end
   end

   // Registered Moore outputs decoded from the next state.
   always_comb begin
      speed_d   = speed_of(state_d);
      turn_en_d = (state_d == ST_TURN);
      alarm_d   = (state_d == ST_FAULT);
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         for (int k = 0; k < N_CH; k++) begin
            sample_q[k] <= '0;
         end
         eval_q    <= 1'b0;
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         retry_q   <= '0;
         wdog_q    <= '0;
         sel_q     <= '0;
         fc_q      <= FC_NONE;
         speed_q   <= 2'd0;
         turn_en_q <= 1'b0;
         alarm_q   <= 1'b0;
      end else begin
         for (int k = 0; k < N_CH; k++) begin
            sample_q[k] <= sample_d[k];
         end
         eval_q    <= eval_d;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         retry_q   <= retry_d;
         wdog_q    <= wdog_d;
         sel_q     <= sel_d;
         fc_q      <= fc_d;
         speed_q   <= speed_d;
         turn_en_q <= turn_en_d;
         alarm_q   <= alarm_d;
      end
   end

   assign speed      = speed_q;
   assign turn_en    = turn_en_q;
   assign turn_sel   = sel_q;
   assign state_o    = state_q;
   assign alarm      = alarm_q;
   assign fault_code = fc_q;

endmodule

// File: tb/tb_robot_nav_ctrl.sv
// -----------------------------------------------------------------------------
// tb_robot_nav_ctrl
// Directed stimulus for robot_nav_ctrl (default parameters). The stimulus
// process queues the expected outputs for specific clock edges. The monitor
// compares them on the falling edge after each of those clock edges.
// -----------------------------------------------------------------------------
module tb_robot_nav_ctrl;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_FWD   = 3'd1;
   localparam logic [2:0] S_SLOW  = 3'd2;
   localparam logic [2:0] S_STOP  = 3'd3;
   localparam logic [2:0] S_TURN  = 3'd4;
   localparam logic [2:0] S_FAULT = 3'd5;

   logic        clk = 1'b0;
   logic        rstn;
   logic [47:0] dist_v;
   logic        dist_valid;
   logic [1:0]  speed;
   logic        turn_en;
   logic [1:0]  turn_sel;
   logic [2:0]  state_o;
   logic        alarm;
   logic [1:0]  fault_code;

   typedef struct {
      int          t;
      logic [10:0] v;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   int   e;
   int   f;

   robot_nav_ctrl dut (
      .clk        (clk),
      .rstn       (rstn),
      .dist_v     (dist_v),
      .dist_valid (dist_valid),
      .speed      (speed),
      .turn_en    (turn_en),
      .turn_sel   (turn_sel),
      .state_o    (state_o),
      .alarm      (alarm),
      .fault_code (fault_code)
   );

   always #5 clk = ~clk;

   // Edge counter: after posedge N, cyc == N.
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: compare every expectation due at this edge.
   always @(negedge clk) begin
      logic [10:0] act;
      exp_t        it;
      act = {state_o, speed, turn_en, turn_sel, alarm, fault_code};
      while ((q.size() > 0) && (q[0].t <= cyc)) begin
         it = q.pop_front();
         checks++;
         if (it.t < cyc) begin
            failures++;
            $display("FAIL missed_check edge=%0d now=%0d", it.t, cyc);
         end else if (act !== it.v) begin
            failures++;
            $display("FAIL outputs edge=%0d got st=%0d spd=%0d te=%0b ts=%0d al=%0b fc=%b want st=%0d spd=%0d te=%0b ts=%0d al=%0b fc=%b",
                     cyc, act[10:8], act[7:6], act[5], act[4:3], act[2], act[1:0],
                     it.v[10:8], it.v[7:6], it.v[5], it.v[4:3], it.v[2], it.v[1:0]);
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_to(input int t);
      while (cyc < t) step(1);
   endtask

   // Present one sample set for a single edge.
   task automatic cap(input int fr, input int c1, input int c2);
      dist_v     = {16'(c2), 16'(c1), 16'(fr)};
      dist_valid = 1'b1;
      step(1);
      dist_valid = 1'b0;
   endtask

   task automatic expect_at(input int t, input logic [2:0] st, input logic [1:0] sp,
                            input logic te, input logic [1:0] ts, input logic al,
                            input logic [1:0] fc);
      exp_t it;
      it.t = t;
      it.v = {st, sp, te, ts, al, fc};
      q.push_back(it);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout cyc=%0d", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      rstn       = 1'b0;
      dist_valid = 1'b0;
      dist_v     = '0;
      step(2);
      expect_at(cyc, S_IDLE, 2'd0, 1'b0, 2'd0, 1'b0, 2'b00);
      rstn = 1'b1;

      // 1: first evaluation, two-cycle latency
      cap(500, 0, 0);
      expect_at(cyc,     S_IDLE, 2'd0, 1'b0, 2'd0, 1'b0, 2'b00);
      expect_at(cyc + 1, S_FWD,  2'd2, 1'b0, 2'd0, 1'b0, 2'b00);
      step(1);

      // 2: slow band and hysteresis
      cap(250, 0, 0); expect_at(cyc + 1, S_SLOW, 2'd1, 1'b0, 2'd0, 1'b0, 2'b00); step(1);
      cap(310, 0, 0); expect_at(cyc + 1, S_SLOW, 2'd1, 1'b0, 2'd0, 1'b0, 2'b00); step(1);
      cap(320, 0, 0); expect_at(cyc + 1, S_FWD,  2'd2, 1'b0, 2'd0, 1'b0, 2'b00); step(1);
      cap(300, 0, 0); expect_at(cyc + 1, S_FWD,  2'd2, 1'b0, 2'd0, 1'b0, 2'b00); step(1);

      // 3: stop, turn toward ch2, recover to SLOW
      cap(50, 200, 400);
      e = cyc;
      for (int k = 1; k <= 4; k++)  expect_at(e + k, S_STOP, 2'd0, 1'b0, 2'd0, 1'b0, 2'b00);
      for (int k = 5; k <= 12; k++) expect_at(e + k, S_TURN, 2'd0, 1'b1, 2'd2, 1'b0, 2'b00);
      expect_at(e + 13, S_SLOW, 2'd1, 1'b0, 2'd2, 1'b0, 2'b00);
      wait_to(e + 6);
      cap(150, 200, 400);
      wait_to(e + 14);

      // 4: three failed attempts then sticky stuck fault; re-latch on retry
      cap(50, 300, 100);
      e = cyc;
      for (int k = 1; k <= 4; k++)   expect_at(e + k, S_STOP, 2'd0, 1'b0, 2'd2, 1'b0, 2'b00);
      for (int k = 5; k <= 12; k++)  expect_at(e + k, S_TURN, 2'd0, 1'b1, 2'd1, 1'b0, 2'b00);
      for (int k = 13; k <= 28; k++) expect_at(e + k, S_TURN, 2'd0, 1'b1, 2'd2, 1'b0, 2'b00);
      expect_at(e + 29, S_FAULT, 2'd0, 1'b0, 2'd2, 1'b1, 2'b10);
      wait_to(e + 6);
      cap(50, 100, 300);
      wait_to(e + 31);
      cap(500, 0, 0);
      expect_at(e + 33, S_FAULT, 2'd0, 1'b0, 2'd2, 1'b1, 2'b10);
      expect_at(e + 34, S_FAULT, 2'd0, 1'b0, 2'd2, 1'b1, 2'b10);
      wait_to(e + 34);
      rstn = 1'b0;
      step(1);
      expect_at(cyc, S_IDLE, 2'd0, 1'b0, 2'd0, 1'b0, 2'b00);
      rstn = 1'b1;

      // 5: watchdog fault, recovery, and dist_valid winning on the 64th cycle
      cap(500, 0, 0);
      e = cyc;
      expect_at(e + 1,  S_FWD,   2'd2, 1'b0, 2'd0, 1'b0, 2'b00);
      expect_at(e + 63, S_FWD,   2'd2, 1'b0, 2'd0, 1'b0, 2'b00);
      expect_at(e + 64, S_FAULT, 2'd0, 1'b0, 2'd0, 1'b1, 2'b01);
      expect_at(e + 66, S_FAULT, 2'd0, 1'b0, 2'd0, 1'b1, 2'b01);
      wait_to(e + 66);
      cap(500, 0, 0);
      f = cyc;
      expect_at(f,      S_IDLE, 2'd0, 1'b0, 2'd0, 1'b0, 2'b00);
      expect_at(f + 1,  S_FWD,  2'd2, 1'b0, 2'd0, 1'b0, 2'b00);
      expect_at(f + 63, S_FWD,  2'd2, 1'b0, 2'd0, 1'b0, 2'b00);
      expect_at(f + 64, S_FWD,  2'd2, 1'b0, 2'd0, 1'b0, 2'b00);
      expect_at(f + 65, S_FWD,  2'd2, 1'b0, 2'd0, 1'b0, 2'b00);
      wait_to(f + 63);
      cap(500, 0, 0);
      step(1);

      // 6: tie picks lowest side index; reset aborts a turn
      cap(50, 200, 200);
      e = cyc;
      for (int k = 1; k <= 4; k++) expect_at(e + k, S_STOP, 2'd0, 1'b0, 2'd0, 1'b0, 2'b00);
      for (int k = 5; k <= 7; k++) expect_at(e + k, S_TURN, 2'd0, 1'b1, 2'd1, 1'b0, 2'b00);
      wait_to(e + 7);
      rstn = 1'b0;
      step(1);
      expect_at(cyc, S_IDLE, 2'd0, 1'b0, 2'd0, 1'b0, 2'b00);
      rstn = 1'b1;

      // 7: threshold boundaries from IDLE and SLOW
      cap(100, 0, 0); expect_at(cyc + 1, S_SLOW, 2'd1, 1'b0, 2'd0, 1'b0, 2'b00); step(1);
      cap(99, 0, 0);  expect_at(cyc + 1, S_STOP, 2'd0, 1'b0, 2'd0, 1'b0, 2'b00); step(1);
      step(3);

      while (q.size() > 0) begin
         exp_t it;
         it = q.pop_front();
         checks++;
         failures++;
         $display("FAIL unchecked edge=%0d now=%0d", it.t, cyc);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/robot_nav_ctrl.md
Name: robot_nav_ctrl

Overview:
Parametrised successor to the single-sensor robot controller. It takes N_CH distance channels (channel 0 front, channels 1..N_CH-1 side), drives speed and turn commands through a Moore FSM, and applies threshold hysteresis, timed stop/turn phases, bounded turn retries and a sensor-staleness watchdog. It sits between the distance-sensor front end and the motor driver.

Parameters:
DIST_W, 16, width of one distance sample (unsigned)
N_CH, 3, number of distance channels (>=1); ch0 = front
STOP_TH, 100, front distance below which the robot stops
SLOW_TH, 300, front distance below which the robot slows (SLOW_TH > STOP_TH)
HYST, 20, hysteresis added to thresholds for upward transitions
STOP_CYC, 4, clock cycles held in STOP before turning
TURN_CYC, 8, clock cycles per turn attempt
MAX_RETRY, 3, consecutive turn attempts before stuck fault
WDOG_CYC, 64, cycles without dist_valid before watchdog fault

Ports:
clk  input  1  clock
rstn  input  1  synchronous reset, active-low
dist_v  input  N_CH*DIST_W  packed samples; ch k at [k*DIST_W +: DIST_W]
dist_valid  input  1  dist_v valid this cycle
speed  output  2  0 stop, 1 slow, 2 fast
turn_en  output  1  turning in progress
turn_sel  output  max(1,$clog2(N_CH))  side channel index selected for turn
state_o  output  3  IDLE=0 FWD=1 SLOW=2 STOP=3 TURN=4 FAULT=5
alarm  output  1  high in FAULT
fault_code  output  2  01 watchdog, 10 stuck; 00 otherwise

Behaviour:
- Reset: clk and rstn only, synchronous, active-low. On an edge with rstn=0: state IDLE, sample regs 0, all counters 0, speed 0, turn_en 0, turn_sel 0, alarm 0, fault_code 0. Reset overrides all other events, including mid-TURN or in FAULT.
- Sampling: dist_valid=1 at edge t captures all channels into the sample regs. The FSM evaluates the captured sample at edge t+1. Outputs decode from the state register, so they change after edge t+1, giving 2-cycle latency. Without dist_valid, the regs hold.
- Comparisons are unsigned. STOP_TH+HYST and SLOW_TH+HYST are computed in DIST_W+1 bits with no wrap. If a sum exceeds the max sample value, its condition is never true.
- Speed rule (front = ch0):
  - front < STOP_TH -> stop band.
  - STOP_TH <= front < SLOW_TH -> slow band.
  - Otherwise fast.
- FSM, distance decisions taken only on the cycle after a capture:
  - IDLE: on first evaluation go to STOP, SLOW or FWD per the speed rule.
  - FWD: front < STOP_TH -> STOP; front < SLOW_TH -> SLOW.
  - SLOW: front < STOP_TH -> STOP; front >= SLOW_TH+HYST -> FWD; else stay.
  - STOP: count STOP_CYC clock cycles, independent of samples. At the end go to TURN, latch turn_sel = argmax of side channels (tie -> lowest index; N_CH=1 -> 0), and set retry=1.
  - TURN: count TURN_CYC cycles. At the end, use the latest sample:
    - front >= STOP_TH+HYST -> SLOW, retry=0.
    - Else if retry == MAX_RETRY -> FAULT, fault_code=10.
    - Else restart TURN, re-latch turn_sel, retry+1.
  - FAULT with fault_code=10 is sticky until reset.
  - FAULT with fault_code=01: the next dist_valid capture -> IDLE, fault_code cleared. IDLE then evaluates normally.
- Watchdog:
  - The counter clears on dist_valid and otherwise increments, saturating.
  - Reaching WDOG_CYC in any non-FAULT state -> FAULT, fault_code=01, and aborts stop/turn counters.
  - If dist_valid occurs on the same cycle the count would hit, dist_valid wins (no fault).
  - The counter is frozen in FAULT.
- Output decode:
  - speed: FWD=2, SLOW=1, else 0.
  - turn_en: 1 only in TURN.
  - alarm: 1 only in FAULT.
  - turn_sel holds its last latched value outside TURN.

Test Plan:
1. Reset; dist_valid 1 cycle with front=500 -> 2 cycles later state_o=1, speed=2, alarm=0.
2. From FWD: front=250 -> SLOW speed=1; front=310 -> stays SLOW; front=320 -> FWD speed=2.
3. Front=50, ch1=200, ch2=400 -> STOP speed=0 for 4 cycles, then TURN turn_en=1, turn_sel=2 for 8 cycles. Front=150 at end -> SLOW, turn_en=0.
4. Front held 50 -> 3 TURN attempts then FAULT alarm=1, fault_code=10. Further valid samples do not exit. rstn=0 one edge -> IDLE, all outputs 0.
5. In FWD, withhold dist_valid for 64 cycles -> FAULT fault_code=01, speed=0. Then dist_valid front=500 -> IDLE, then FWD. Variant: dist_valid on the 64th cycle -> no fault.
6. Sides ch1=ch2=200 -> turn_sel=1. rstn=0 on TURN cycle 3 -> next edge state_o=0, turn_en=0, turn_sel=0.
